// File: rtl/homomorphic_add_ctrl.sv
// Sequencer that streams two ciphertext vectors through a lane-parallel modular adder
// into a result memory. It handles the start/done handshake, the 1-cycle read latency and write back-pressure.
module homomorphic_add_ctrl #(
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int PARALLEL         = 1,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                num_words,
  input  logic [ADDR_WIDTH-1:0]                base_a,
  input  logic [ADDR_WIDTH-1:0]                base_b,
  input  logic [ADDR_WIDTH-1:0]                base_r,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr_a,
  output logic [ADDR_WIDTH-1:0]                rd_addr_b,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] rd_data_a,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] rd_data_b,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] wr_data,
  input  logic                                 wr_ready
);

  localparam int WORD_W = PARALLEL * CIPHERTEXT_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] n_words, base_a_q, base_b_q, base_r_q;
  logic [ADDR_WIDTH-1:0] rd_cnt, ld_cnt, wr_cnt;
  logic                  vld_p1;
  logic [WORD_W-1:0]     sum_p1;
  logic                  skid_vld;
  logic [WORD_W-1:0]     skid_data;
  logic                  out_free, wr_fire, last_wr, rd_issue;

  // Lane-wise add; each lane result is truncated, so no carry crosses a lane boundary.
  function automatic logic [WORD_W-1:0] add_lanes(input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
    logic [WORD_W-1:0] s;
    s = '0;
    for (int i = 0; i < PARALLEL; i++) begin
      s[i*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH] =
        a[i*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH] + b[i*CIPHERTEXT_WIDTH +: CIPHERTEXT_WIDTH];
    end
    return s;
  endfunction

  always_comb begin
    out_free  = !wr_en || wr_ready;
    wr_fire   = wr_en && wr_ready;
    last_wr   = wr_fire && (wr_cnt == n_words - ONE);
    // A read is only launched when its data is guaranteed a free slot on return.
    rd_issue  = (state == RUN) && (rd_cnt < n_words) && !skid_vld && out_free;
    rd_en     = rd_issue;
    rd_addr_a = base_a_q + rd_cnt;
    rd_addr_b = base_b_q + rd_cnt;
    done      = (state == FINISH);
    sum_p1    = add_lanes(rd_data_a, rd_data_b);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_words == '0) ? FINISH : RUN;
      RUN:     if (last_wr) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      n_words   <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      base_r_q  <= '0;
      rd_cnt    <= '0;
      ld_cnt    <= '0;
      wr_cnt    <= '0;
      vld_p1    <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      if (state == IDLE && start) busy <= 1'b1;
      else if (last_wr || state == FINISH) busy <= 1'b0;

      // Stage p1: read data returns, sum formed combinationally
      vld_p1 <= rd_issue;
      if (rd_issue) rd_cnt <= rd_cnt + ONE;
      if (wr_fire)  wr_cnt <= wr_cnt + ONE;

      // Stage p2: registered write port, fed from skid first to keep order
      if (out_free) begin
        if (skid_vld) begin
          wr_en     <= 1'b1;
          wr_data   <= skid_data;
          wr_addr   <= base_r_q + ld_cnt;
          ld_cnt    <= ld_cnt + ONE;
          skid_vld  <= vld_p1;
          skid_data <= sum_p1;
        end else if (vld_p1) begin
          wr_en   <= 1'b1;
          wr_data <= sum_p1;
          wr_addr <= base_r_q + ld_cnt;
          ld_cnt  <= ld_cnt + ONE;
        end else begin
          wr_en <= 1'b0;
        end
      end else if (vld_p1) begin
        skid_vld  <= 1'b1;
        skid_data <= sum_p1;
      end

      if (state == IDLE && start) begin
        n_words  <= num_words;
        base_a_q <= base_a;
        base_b_q <= base_b;
        base_r_q <= base_r;
        rd_cnt   <= '0;
        ld_cnt   <= '0;
        wr_cnt   <= '0;
        vld_p1   <= 1'b0;
        skid_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_homomorphic_add_ctrl.sv
// Directed bench for homomorphic_add_ctrl with 4 lanes of 10 bits and registered-read memory models.
module tb_homomorphic_add_ctrl;

  localparam int CW = 10;
  localparam int P  = 4;
  localparam int AW = 8;

  logic          clk, rst, start, busy, done, rd_en, wr_en, wr_ready;
  logic [AW-1:0] num_words, base_a, base_b, base_r, rd_addr_a, rd_addr_b, wr_addr;
  logic [P*CW-1:0] rd_data_a, rd_data_b, wr_data;

  logic [P*CW-1:0] mem_a [256];
  logic [P*CW-1:0] mem_b [256];

  logic [AW-1:0]   wa [1024];
  logic [P*CW-1:0] wd [1024];
  logic [9:0]      wn = '0;
  logic            prev_stall = 1'b0;
  logic [AW-1:0]   prev_addr = '0;
  logic [P*CW-1:0] prev_data = '0;
  int              stab_err = 0, rd_err = 0, dw_err = 0;

  int tests = 0, fails = 0;

  homomorphic_add_ctrl #(.CIPHERTEXT_WIDTH(CW), .PARALLEL(P), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .base_a(base_a), .base_b(base_b), .base_r(base_r),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  // Write log plus protocol watchers: stall stability, read-during-stall, done overlapping a write.
  always @(posedge clk) begin
    if (wr_en && wr_ready) begin
      wa[wn] <= wr_addr;
      wd[wn] <= wr_data;
      wn     <= wn + 10'd1;
    end
    if (prev_stall && (!wr_en || wr_addr != prev_addr || wr_data != prev_data))
      stab_err <= stab_err + 1;
    if (rd_en && wr_en && !wr_ready) rd_err <= rd_err + 1;
    if (done && wr_en) dw_err <= dw_err + 1;
    prev_stall <= wr_en && !wr_ready;
    prev_addr  <= wr_addr;
    prev_data  <= wr_data;
  end

  function automatic logic [P*CW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {l3[9:0], l2[9:0], l1[9:0], l0[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 1 (just after the edge that samples start).
  task automatic do_start(input logic [AW-1:0] n, input logic [AW-1:0] ba,
                          input logic [AW-1:0] bb, input logic [AW-1:0] br);
    num_words = n; base_a = ba; base_b = bb; base_r = br;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 300) begin
      tick();
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    int c;
    logic [9:0] w0, w1;
    rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
    num_words = '0; base_a = '0; base_b = '0; base_r = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int k = 0; k < 3; k++) begin
      mem_a[k]      = pack4(1, 2, 3, 4);
      mem_b[16 + k] = pack4(10, 20, 30, 40);
    end
    mem_a[40] = pack4(1023, 1000, 5, 0);
    mem_b[56] = pack4(1, 100, 7, 0);
    mem_a[41] = pack4(5, 6, 7, 8);
    mem_b[57] = pack4(1, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      mem_a[100 + k] = pack4(k, 2 * k + 1, 1000, 3);
      mem_b[150 + k] = pack4(10 * k, 24, 30 + k, 1021);
    end

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr_a", rd_addr_a, 0);
    chk("rst_rd_addr_b", rd_addr_b, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    tick();

    // Basic run
    do_start(8'd3, 8'd0, 8'd16, 8'd32);
    chk("b_c1_busy", busy, 1);
    chk("b_c1_rd_en", rd_en, 1);
    chk("b_c1_rd_addr_a", rd_addr_a, 0);
    chk("b_c1_rd_addr_b", rd_addr_b, 16);
    chk("b_c1_wr_en", wr_en, 0);
    tick();
    chk("b_c2_wr_en", wr_en, 0);
    chk("b_c2_rd_addr_a", rd_addr_a, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b_wr_en", wr_en, 1);
      chk("b_wr_addr", wr_addr, 32 + k);
      chk("b_wr_data", wr_data, pack4(11, 22, 33, 44));
      chk("b_no_done", done, 0);
    end
    tick();
    chk("b_c6_done", done, 1);
    chk("b_c6_busy", busy, 0);
    chk("b_c6_wr_en", wr_en, 0);
    tick();
    chk("b_c7_done", done, 0);

    // Modular wrap within lanes
    w0 = wn;
    do_start(8'd1, 8'd40, 8'd56, 8'd72);
    wait_done(1, c);
    chk("m_done_cycle", c, 4);
    chk("m_count", wn - w0, 1);
    chk("m_addr", wa[w0], 72);
    chk("m_data", wd[w0], pack4(0, 76, 12, 0));
    tick();

    // Back-pressure with wr_ready pattern 1,0,0,1
    w0 = wn;
    do_start(8'd8, 8'd100, 8'd150, 8'd200);
    c = 1;
    while (!done && c < 300) begin
      wr_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      tick();
      c++;
    end
    wr_ready = 1'b1;
    chk("bp_done_seen", done, 1);
    chk("bp_count", wn - w0, 8);
    for (int k = 0; k < 8; k++) begin
      chk("bp_addr", wa[w0 + 10'(k)], 200 + k);
      chk("bp_data", wd[w0 + 10'(k)], pack4(11 * k, 2 * k + 25, 6 + k, 0));
    end
    chk("bp_stable", stab_err, 0);
    chk("bp_rd_in_stall", rd_err, 0);
    tick();

    // Address wrap
    do_start(8'd4, 8'd254, 8'd10, 8'd210);
    chk("aw_rd_en0", rd_en, 1);
    chk("aw_addr0", rd_addr_a, 254);
    tick();
    chk("aw_addr1", rd_addr_a, 255);
    tick();
    chk("aw_addr2", rd_addr_a, 0);
    chk("aw_addr2_b", rd_addr_b, 12);
    tick();
    chk("aw_addr3", rd_addr_a, 1);
    chk("aw_rd_en3", rd_en, 1);
    wait_done(4, c);
    chk("aw_done_cycle", c, 7);
    tick();

    // Zero-length run
    w0 = wn;
    do_start(8'd0, 8'd5, 8'd6, 8'd7);
    chk("z_busy", busy, 1);
    chk("z_done", done, 1);
    chk("z_rd_en", rd_en, 0);
    chk("z_wr_en", wr_en, 0);
    tick();
    chk("z_busy2", busy, 0);
    chk("z_done2", done, 0);
    chk("z_rd_en2", rd_en, 0);
    chk("z_count", wn - w0, 0);

    // Start during RUN is ignored
    w0 = wn;
    do_start(8'd3, 8'd0, 8'd16, 8'd32);
    tick();
    num_words = 8'd9; base_r = 8'd99; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3, c);
    chk("s_done_cycle", c, 6);
    chk("s_count", wn - w0, 3);
    chk("s_last_addr", wa[wn - 10'd1], 34);
    tick();
    chk("s_idle_busy", busy, 0);
    chk("s_idle_rd_en", rd_en, 0);

    // Reset mid-run
    do_start(8'd10, 8'd0, 8'd16, 8'd120);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_rd_en", rd_en, 0);
    chk("r_rd_addr_a", rd_addr_a, 0);
    chk("r_wr_en", wr_en, 0);
    chk("r_wr_addr", wr_addr, 0);
    chk("r_wr_data", wr_data, 0);
    rst = 1'b0;
    tick();
    w1 = wn;
    do_start(8'd2, 8'd40, 8'd56, 8'd80);
    wait_done(1, c);
    chk("r2_done_cycle", c, 5);
    chk("r2_count", wn - w1, 2);
    chk("r2_addr0", wa[w1], 80);
    chk("r2_data0", wd[w1], pack4(0, 76, 12, 0));
    chk("r2_addr1", wa[w1 + 10'd1], 81);
    chk("r2_data1", wd[w1 + 10'd1], pack4(6, 7, 8, 9));
    tick();
    chk("done_with_wr_en", dw_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
